legv8_register_file: RTL

The LEGv8 integer register file: 32 × 64-bit registers, two combinational read ports, one clocked write port. It sits directly downstream of the Reg2Loc 5-bit selector. Read port 1 takes Rn (Inst[9:5]). Read port 2 takes the selector output, which is Rm (Inst[20:16]) or Rt (Inst[4:0]). The write port takes Rd/Rt from write-back. Register 31 is XZR: it always reads zero and ignores writes.

---
 rtl/legv8_register_file_if.sv | 24 ++
 rtl/legv8_register_file.sv | 48 ++++
 2 files changed

// File: rtl/legv8_register_file_if.sv
// Register file access bundle: two read ports, one write port.
// The datapath drives indices and write-back; the register file answers.
interface legv8_register_file_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic [ADDR_WIDTH-1:0] WriteReg;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;

    modport master (
        output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/legv8_register_file.sv
// LEGv8 integer register file: 32 x 64-bit, two combinational reads,
// one clocked write, XZR hard-wired to zero, same-cycle write bypass.
module legv8_register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic CLK,
    input  logic RESET,
    legv8_register_file_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_en;

    // Writes to XZR or during reset never reach the array or the bypass.
    assign write_en = bus.RegWrite && !RESET && (bus.WriteReg != ZERO_IDX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    always_comb begin
        bus.ReadData1 = regs[bus.ReadReg1];
        if (RESET || bus.ReadReg1 == ZERO_IDX) begin
            bus.ReadData1 = '0;
        end else if (write_en && bus.WriteReg == bus.ReadReg1) begin
            bus.ReadData1 = bus.WriteData;
        end
    end

    always_comb begin
        bus.ReadData2 = regs[bus.ReadReg2];
        if (RESET || bus.ReadReg2 == ZERO_IDX) begin
            bus.ReadData2 = '0;
        end else if (write_en && bus.WriteReg == bus.ReadReg2) begin
            bus.ReadData2 = bus.WriteData;
        end
    end
endmodule
